noc_port_arbiter: RTL and testbench
===================================

// Module: noc_port_arbiter
// PURPOSE
//  Clocked 3:1 round-robin arbiter for one router output port. It merges three
//  flit streams (e.g. async/left/bottom toward right) into one registered output
//  slice. Used in the synchronous router variant where each of the four output
//  ports owns one instance. Flits pass through unmodified; the block only picks
//  the winner and buffers it.
// PARAMETERS
//  WIDTH      12  flit width: [0] type, [3:1] dest router, [WIDTH-1:4] payload
//  NUM_REQ     3  requester count; fixed at 3, elaboration error otherwise
// PORTS
//  clk        in   1        clock, rising-edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   3        per-requester flit valid
//  in_data    in   3*WIDTH  flits; requester i at [i*WIDTH +: WIDTH]
//  in_ready   out  3        one-hot or zero; flit i accepted when valid&ready
//  out_valid  out  1        output slice holds a flit
//  out_data   out  WIDTH    buffered flit
//  out_src    out  2        index of requester that sent out_data (0..2)
//  out_ready  in   1        downstream accepts when out_valid&out_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0,
//    ptr=0. in_ready is combinational and is 0 while rst_n=0.
//  - accept = !out_valid | out_ready. The slice reloads in the same cycle it
//    drains, so sustained throughput is 1 flit/clk.
//  - Grant: search order ptr, ptr+1, ptr+2 (mod 3). The first i with
//    in_valid[i] wins. in_ready[i] = accept & win[i]; every other in_ready is 0.
//  - Capture on posedge when valid&ready for winner i: out_data<=flit i,
//    out_src<=i, out_valid<=1, ptr<=(i+1) mod 3.
//  - Drain with no capture: out_valid<=0. out_data and out_src keep their
//    values.
//  - No capture: ptr holds. Idle cycles do not rotate priority.
//  - ptr==3 is unreachable. If ptr==3, it is treated as 0 and rewritten to a
//    legal value on the next capture.
//  - Latency: flit accepted in cycle N appears on out_* in cycle N+1.
//  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
//    EMPTY->FULL on capture.
//    FULL->FULL on stall (out_ready=0) or on drain+capture.
//    FULL->EMPTY on drain without capture.
//  - Stall: with out_ready=0 in FULL, out_data, out_src and ptr are held and
//    all in_ready=0.
//  - Protocol: once asserted, in_valid[i] and flit i stay stable until
//    accepted. Bench asserts this. The block does not depend on it for safety.
//  - Fairness: with all 3 requesters continuously valid and out_ready=1,
//    grants cycle 0,1,2,0,... and no requester waits more than 2 grants.
//  - Reset mid-operation: a buffered flit is discarded. ptr returns to 0.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined:
//    - Adds output port grant_cnt (out, 3*16): per-requester 16-bit counters,
//      +1 on each capture from that requester.
//    - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
//  ARB_PERF_CNT_EN undefined:
//    - Port and counters are absent; behaviour is otherwise identical.
// TESTING
//  1 Reset: rst_n=0 with in_valid=3'b111 -> out_valid=0, in_ready=0, out_src=0;
//    after release the first grant goes to requester 0.
//  2 Single requester: in_valid=3'b010, flit 12'h5A2, out_ready=1 ->
//    in_ready=3'b010; next clk out_valid=1, out_data=12'h5A2, out_src=1.
//  3 Round robin: in_valid=3'b111 held for 6 clk, out_ready=1 ->
//    out_src sequence 0,1,2,0,1,2 and 1 flit/clk.
//  4 Backpressure: FULL with out_ready=0 for 4 clk -> in_ready=0, out_* stable;
//    release -> drain and capture in the same clk, no bubble.
//  5 Skip idle: ptr=1 with in_valid=3'b101 -> grant 2, then ptr=0 and grant 0.
//  6 Async reset while FULL between edges -> out_valid drops immediately;
//    with ARB_PERF_CNT_EN defined, grant_cnt=0 and counters saturate after
//    65535+ grants.

Source files
------------

// File: rtl/noc_port_arbiter.sv
// Purpose     : 3:1 round-robin arbiter feeding one registered output slice of a router port.
// Latency     : 1 clk from in_valid&in_ready to out_valid.
// Backpressure: out_ready=0 while full holds the slice and drops every in_ready; drain and reload share a clock.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid[3]           per-requester flit valid
//   in_data[3*WIDTH]      flits, requester i at [i*WIDTH +: WIDTH]
//   in_ready[3]           one-hot or zero, combinational grant qualified by slice space
//   out_valid/out_data    buffered flit
//   out_src[2]            index of the requester that sent out_data
//   out_ready             downstream accept
//   grant_cnt[3*16]       per-requester saturating capture counters (only with ARB_PERF_CNT_EN)
//
// Optional feature macro: ARB_PERF_CNT_EN (adds grant_cnt and its counters).

module noc_port_arbiter #(
  parameter int WIDTH   = 12,
  parameter int NUM_REQ = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       in_valid,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]       in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_src,
`ifdef ARB_PERF_CNT_EN
  output logic [3*16-1:0]          grant_cnt,
`endif
  input  logic                     out_ready
);

  // The grant search and counter layout are written for exactly three requesters.
  generate
    if (NUM_REQ != 3) begin : g_bad_num_req
      $error("noc_port_arbiter: NUM_REQ must be 3");
    end
  endgenerate

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [1:0]         src_q, src_d;

  logic [1:0]         ptr_eff;
  logic [1:0]         cand0, cand1, cand2;
  logic [1:0]         win_idx;
  logic               win_any;
  logic               accept;
  logic               capture;
  logic [WIDTH-1:0]   win_flit;

  // Successor modulo 3 for legal indices 0..2.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Grant: first valid requester starting at the priority pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    // ptr==3 cannot be reached from reset; treat it as 0 so the search stays legal.
    ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    cand0   = ptr_eff;
    cand1   = inc3(cand0);
    cand2   = inc3(cand1);

    win_idx = 2'd0;
    win_any = 1'b0;
    if (in_valid[cand0]) begin
      win_idx = cand0;
      win_any = 1'b1;
    end else if (in_valid[cand1]) begin
      win_idx = cand1;
      win_any = 1'b1;
    end else if (in_valid[cand2]) begin
      win_idx = cand2;
      win_any = 1'b1;
    end
  end

  always_comb begin
    // The slice can take a flit when empty or when it drains this clock.
    accept = (state_q == ST_EMPTY) | out_ready;
    // rst_n gating keeps in_ready low during reset even though it is combinational.
    capture = rst_n & accept & win_any;

    in_ready = '0;
    if (capture) begin
      in_ready[win_idx] = 1'b1;
    end

    case (win_idx)
      2'd0:    win_flit = in_data[0*WIDTH +: WIDTH];
      2'd1:    win_flit = in_data[1*WIDTH +: WIDTH];
      default: win_flit = in_data[2*WIDTH +: WIDTH];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slice FSM and datapath next-state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;

    case (state_q)
      ST_EMPTY: begin
        if (capture) state_d = ST_FULL;
      end
      ST_FULL: begin
        // Drain+capture stays FULL; a stall also stays FULL.
        if (out_ready && !capture) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    // Priority rotates only on an actual capture; idle cycles leave it alone.
    if (capture) begin
      data_d = win_flit;
      src_d  = win_idx;
      ptr_d  = inc3(win_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Per-requester capture counters, saturating at all-ones.
  // ---------------------------------------------------------------------------
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (capture && (win_idx == 2'(k)) && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) cnt_q[k] <= 16'd0;
    end else begin
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign grant_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Purpose     : self-checking bench for noc_port_arbiter with a scoreboard on the output slice.
// Latency     : expected flits are queued when issued; a negedge monitor pops one per output transfer.
// Backpressure: stalls are driven directly and the held slice is checked each stalled cycle.

module tb_noc_port_arbiter;

  localparam int WIDTH = 12;
  localparam logic [WIDTH-1:0] F0 = 12'h3C1;
  localparam logic [WIDTH-1:0] F1 = 12'h5A2;
  localparam logic [WIDTH-1:0] F2 = 12'h7E5;

  logic                 clk;
  logic                 rst_n;
  logic [2:0]           in_valid;
  logic [3*WIDTH-1:0]   in_data;
  logic [2:0]           in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_src;
  logic                 out_ready;
`ifdef ARB_PERF_CNT_EN
  logic [3*16-1:0]      grant_cnt;
`endif

  int n_checks;
  int n_errors;
  logic [13:0] exp_q[$];

  noc_port_arbiter #(.WIDTH(WIDTH), .NUM_REQ(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
`ifdef ARB_PERF_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] flit_of(input int k);
    case (k)
      0:       return F0;
      1:       return F1;
      default: return F2;
    endcase
  endfunction

  task automatic push(input int src, input logic [WIDTH-1:0] d);
    exp_q.push_back({2'(src), d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the coming posedge whenever valid&ready here.
  always @(negedge clk) begin
    logic [13:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_flit", 48'(out_valid), 48'd0);
      end else begin
        e = exp_q.pop_front();
        check("mon_src",  48'(out_src),  48'(e[13:12]));
        check("mon_data", 48'(out_data), 48'(e[11:0]));
      end
    end
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_data   = {F2, F1, F0};
    in_valid  = 3'b111;

    // 1: reset state with all requesters valid
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 48'(out_valid), 48'd0);
    check("rst_in_ready",  48'(in_ready),  48'd0);
    check("rst_out_src",   48'(out_src),   48'd0);
    check("rst_out_data",  48'(out_data),  48'd0);
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", 48'(in_ready), 48'd1);
    push(0, F0);
    tick();
    in_valid = 3'b000;

    // 2: single requester 1 (ptr now 1)
    in_valid = 3'b010;
    #1;
    check("single_in_ready", 48'(in_ready), 48'b010);
    push(1, F1);
    tick();
    in_valid = 3'b000;
    #1;
    check("single_out_valid", 48'(out_valid), 48'd1);
    check("single_out_data",  48'(out_data),  48'h5A2);
    check("single_out_src",   48'(out_src),   48'd1);

    // bring ptr from 2 back to 0 with one grant to requester 2
    in_valid = 3'b100;
    push(2, F2);
    tick();
    in_valid = 3'b000;

    // 3: round robin, all valid for 6 clocks, one grant per clock
    in_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_in_ready", 48'(in_ready), 48'(1 << (i % 3)));
      push(i % 3, flit_of(i % 3));
      tick();
    end

    // 4: backpressure, slice holds requester 2's flit
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready",  48'(in_ready),  48'd0);
      check("stall_out_valid", 48'(out_valid), 48'd1);
      check("stall_out_src",   48'(out_src),   48'd2);
      check("stall_out_data",  48'(out_data),  48'(F2));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 48'(in_ready), 48'd1);
    push(0, F0);
    tick();
    in_valid = 3'b000;

    // 5: ptr=1 with requesters 0 and 2 valid -> 2 then 0
    in_valid = 3'b101;
    #1;
    check("skip_grant2", 48'(in_ready), 48'b100);
    push(2, F2);
    tick();
    #1;
    check("skip_grant0", 48'(in_ready), 48'b001);
    push(0, F0);
    tick();
    in_valid = 3'b000;

    // idle cycles leave ptr at 1
    repeat (3) tick();
    in_valid = 3'b111;
    #1;
    check("idle_no_rotate", 48'(in_ready), 48'b010);
    push(1, F1);
    tick();
    in_valid = 3'b000;

    // 6: async reset while FULL (ptr=2 beforehand)
    tick();
    out_ready = 1'b0;
    in_valid  = 3'b010;
    #1;
    check("pre_rst_grant", 48'(in_ready), 48'b010);
    tick();
    in_valid = 3'b111;
    check("pre_rst_full", 48'(out_valid), 48'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 48'(out_valid), 48'd0);
    check("arst_in_ready",  48'(in_ready),  48'd0);
    check("arst_out_src",   48'(out_src),   48'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_grant0", 48'(in_ready), 48'd1);
    push(0, F0);
    tick();
    in_valid = 3'b000;

`ifdef ARB_PERF_CNT_EN
    check("cnt_after_rst", 48'(grant_cnt), {16'd0, 16'd0, 16'd1});
    in_valid = 3'b001;
    for (int i = 0; i < 65540; i++) begin
      push(0, F0);
      tick();
    end
    in_valid = 3'b000;
    check("cnt_saturate", 48'(grant_cnt), {16'd0, 16'd0, 16'hFFFF});
`endif

    // let the scoreboard drain, bounded
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
